// File: rtl/dmem_controller_if.sv
// Bus between the MEM-stage memory interface (master) and the data-memory back end (slave).
interface dmem_controller_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [3:0]  byte_enable;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic        mem_ready;
    logic        mem_stall;
    logic        access_fault;

    modport master (
        output mem_addr, mem_data_out, byte_enable, mem_read_en, mem_write_en,
        input  mem_data_in, mem_ready, mem_stall, access_fault
    );

    modport slave (
        input  mem_addr, mem_data_out, byte_enable, mem_read_en, mem_write_en,
        output mem_data_in, mem_ready, mem_stall, access_fault
    );
endinterface

// File: rtl/dmem_controller.sv
// Word-organised data RAM with programmable wait states; stalls the pipeline until each
// access completes and flags out-of-range accesses.
module dmem_controller #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    dmem_controller_if.slave   bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic           r_oor;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;
    logic           r_is_wr;
    logic [31:0]    r_data_in;
    logic           r_ready;
    logic           r_fault;
    logic [31:0]    r_ram [DEPTH_WORDS];

    logic           w_req;
    logic [31:0]    w_offset;
    logic [AW-1:0]  w_in_idx;
    logic           w_in_oor;
    logic           w_idle;
    logic [AW-1:0]  w_cur_idx;
    logic           w_cur_oor;
    logic [31:0]    w_cur_wdata;
    logic [3:0]     w_cur_be;
    logic           w_cur_wr;
    logic           w_commit;
    logic           w_ram_we;
    logic           w_unused_lsb;

    assign w_req        = bus.mem_read_en | bus.mem_write_en;
    assign w_offset     = bus.mem_addr - BASE_ADDR;
    assign w_in_idx     = w_offset[AW+1:2];
    assign w_in_oor     = |w_offset[31:AW+2];
    assign w_unused_lsb = ^w_offset[1:0];
    assign w_idle       = (r_state == ST_IDLE);

    // With zero wait states the commit happens on the IDLE edge, so live inputs are used there.
    always_comb begin
        w_cur_idx   = w_idle ? w_in_idx           : r_idx;
        w_cur_oor   = w_idle ? w_in_oor           : r_oor;
        w_cur_wdata = w_idle ? bus.mem_data_out   : r_wdata;
        w_cur_be    = w_idle ? bus.byte_enable    : r_be;
        w_cur_wr    = w_idle ? bus.mem_write_en   : r_is_wr;
        w_commit    = reset & w_req &
                      ((w_idle & NO_WAIT) | ((r_state == ST_WAIT) & (r_cnt == 4'd0)));
        w_ram_we    = w_commit & w_cur_wr & ~w_cur_oor;
    end

    // Access sequencing, request latching and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_oor     <= 1'b0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_is_wr   <= 1'b0;
            r_data_in <= 32'd0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_in_idx;
                        r_oor   <= w_in_oor;
                        r_wdata <= bus.mem_data_out;
                        r_be    <= bus.byte_enable;
                        r_is_wr <= bus.mem_write_en;
                        if (NO_WAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_commit) begin
                r_ready <= 1'b1;
                r_fault <= w_cur_oor;
                if (!w_cur_wr) begin
                    r_data_in <= w_cur_oor ? 32'd0 : r_ram[w_cur_idx];
                end else begin
                    r_data_in <= r_data_in;
                end
            end else begin
                r_data_in <= r_data_in;
            end
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && w_cur_be[i]) begin
                r_ram[w_cur_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
            end
        end
    end

    assign bus.mem_data_in  = r_data_in;
    assign bus.mem_ready    = r_ready;
    assign bus.access_fault = r_fault;
    assign bus.mem_stall    = (w_idle & w_req) | (r_state == ST_WAIT);
endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: three instances with 0, 1 and 2 wait states, each checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_dmem_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   run = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic [3:0]  t_be    [3];
    logic        t_rd    [3];
    logic        t_wr    [3];
    logic [31:0] d_data  [3];
    logic        d_ready [3];
    logic        d_stall [3];
    logic        d_fault [3];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = g;
        dmem_controller_if bus ();

        assign bus.mem_addr     = t_addr[g];
        assign bus.mem_data_out = t_wdata[g];
        assign bus.byte_enable  = t_be[g];
        assign bus.mem_read_en  = t_rd[g];
        assign bus.mem_write_en = t_wr[g];
        assign d_data[g]  = bus.mem_data_in;
        assign d_ready[g] = bus.mem_ready;
        assign d_stall[g] = bus.mem_stall;
        assign d_fault[g] = bus.access_fault;

        dmem_controller #(
            .DEPTH_WORDS (1024),
            .WAIT_STATES (WS),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Transaction model: an access first seen on one edge completes WS edges later
        // unless the request is withdrawn; the following cycle is the response cycle.
        logic [31:0] m_mem [1024];
        bit          m_pend = 1'b0;
        bit          m_resp = 1'b0;
        bit          m_flt  = 1'b0;
        logic [31:0] m_data = 32'd0;
        int          m_age  = 0;
        logic [31:0] l_addr, l_wd;
        logic [3:0]  l_be;
        bit          l_wr;
        wire         m_req = t_rd[g] | t_wr[g];

        initial begin : model
            forever begin
                @(posedge clk or negedge reset);
                if (!reset) begin
                    m_pend = 1'b0; m_resp = 1'b0; m_flt = 1'b0; m_data = 32'd0;
                end else if (m_resp) begin
                    m_resp = 1'b0;
                end else begin
                    if (!m_pend && m_req) begin
                        m_pend = 1'b1; m_age = 0;
                        l_addr = t_addr[g]; l_wd = t_wdata[g]; l_be = t_be[g]; l_wr = t_wr[g];
                    end else if (m_pend && !m_req) begin
                        m_pend = 1'b0;
                    end else if (m_pend) begin
                        m_age++;
                    end
                    if (m_pend && m_age == WS) begin
                        m_pend = 1'b0;
                        m_resp = 1'b1;
                        m_flt  = (l_addr - 32'h0000_0000) >= 32'd4096;
                        if (l_wr) begin
                            if (!m_flt)
                                for (int i = 0; i < 4; i++)
                                    if (l_be[i]) m_mem[l_addr[11:2]][8*i +: 8] = l_wd[8*i +: 8];
                        end else begin
                            m_data = m_flt ? 32'd0 : m_mem[l_addr[11:2]];
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (run) begin
                check($sformatf("u%0d ready", g), {31'd0, d_ready[g]}, {31'd0, m_resp});
                check($sformatf("u%0d fault", g), {31'd0, d_fault[g]}, {31'd0, m_resp & m_flt});
                check($sformatf("u%0d stall", g), {31'd0, d_stall[g]},
                      {31'd0, (!m_resp && !m_pend && m_req) || m_pend});
                check($sformatf("u%0d data", g), d_data[g], m_data);
            end
        end
    end

    task automatic acc(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       output logic [31:0] rdata, output logic flt);
        bit got = 1'b0;
        int lat = 0;
        int stl = 0;
        rdata = 32'd0;
        flt   = 1'b0;
        @(posedge clk); #1;
        t_addr[k] = addr; t_wdata[k] = data; t_be[k] = be; t_rd[k] = rd; t_wr[k] = wr;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (d_stall[k]) stl++;
            if (d_ready[k]) begin
                got = 1'b1; lat = c; rdata = d_data[k]; flt = d_fault[k];
            end
        end
        check($sformatf("u%0d ready seen", k), {31'd0, got}, 32'd1);
        check($sformatf("u%0d latency", k), lat, k + 1);
        check($sformatf("u%0d stall cycles", k), stl, k + 1);
        @(posedge clk); #1;
        t_rd[k] = 1'b0; t_wr[k] = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        f;
        bit          seen;
        for (int i = 0; i < 3; i++) begin
            t_addr[i] = 32'd0; t_wdata[i] = 32'd0; t_be[i] = 4'd0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
        end
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        run = 1'b1;

        // Reset in the middle of a pending write (2 wait states).
        acc(2, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 4'hF, rd, f);
        acc(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, f);
        check("u2 read before reset", rd, 32'h1111_1111);
        @(posedge clk); #1;
        t_addr[2] = 32'h10; t_wdata[2] = 32'hDEAD_BEEF; t_be[2] = 4'hF; t_wr[2] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; t_wr[2] = 1'b0;
        #1;
        check("reset data", d_data[2], 32'd0);
        check("reset ready", {31'd0, d_ready[2]}, 32'd0);
        check("reset stall", {31'd0, d_stall[2]}, 32'd0);
        check("reset fault", {31'd0, d_fault[2]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        acc(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, f);
        check("u2 write discarded", rd, 32'h1111_1111);

        // Word write/read and byte-lane merges with 1 wait state.
        acc(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, f);
        acc(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, f);
        check("u1 word read", rd, 32'h1234_5678);
        acc(1, 1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'hF, rd, f);
        acc(1, 1'b0, 1'b1, 32'h40, 32'h00EE_0000, 4'b0100, rd, f);
        acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, rd, f);
        check("u1 lane2 merge", rd, 32'hAAEE_CCDD);
        acc(1, 1'b0, 1'b1, 32'h40, 32'h0000_1122, 4'b0011, rd, f);
        acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, rd, f);
        check("u1 lane10 merge", rd, 32'hAAEE_1122);
        acc(1, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, f);
        acc(1, 1'b1, 1'b0, 32'h42, 32'h0, 4'hF, rd, f);
        check("u1 be0 write", rd, 32'hAAEE_1122);

        // Both strobes: write wins, read data untouched.
        acc(1, 1'b1, 1'b1, 32'h24, 32'h9999_9999, 4'hF, rd, f);
        check("u1 rw keeps data", rd, 32'hAAEE_1122);
        acc(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, rd, f);
        check("u1 rw committed", rd, 32'h9999_9999);

        // Out-of-range accesses.
        acc(1, 1'b0, 1'b1, 32'h0, 32'h0102_0304, 4'hF, rd, f);
        acc(1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, rd, f);
        check("u1 oor read fault", {31'd0, f}, 32'd1);
        check("u1 oor read data", rd, 32'd0);
        acc(1, 1'b0, 1'b1, 32'h1000, 32'h5555_5555, 4'hF, rd, f);
        check("u1 oor write fault", {31'd0, f}, 32'd1);
        acc(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, f);
        check("u1 ram unchanged", rd, 32'h0102_0304);
        check("u1 in-range no fault", {31'd0, f}, 32'd0);
        acc(1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, rd, f);
        check("u1 wrap fault", {31'd0, f}, 32'd1);

        // Zero wait states, consecutive reads.
        acc(0, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, f);
        acc(0, 1'b0, 1'b1, 32'h4, 32'h0BAD_C0DE, 4'hF, rd, f);
        acc(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, f);
        check("u0 read 0x0", rd, 32'hCAFE_F00D);
        acc(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, f);
        check("u0 read 0x4", rd, 32'h0BAD_C0DE);

        // Read withdrawn during WAIT (2 wait states).
        acc(2, 1'b0, 1'b1, 32'h14, 32'h7777_7777, 4'hF, rd, f);
        acc(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, f);
        @(posedge clk); #1;
        t_addr[2] = 32'h14; t_rd[2] = 1'b1;
        @(posedge clk); #1;
        t_rd[2] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ready[2]) seen = 1'b1;
        end
        check("u2 abort no ready", {31'd0, seen}, 32'd0);
        check("u2 abort data", d_data[2], 32'h1111_1111);
        acc(2, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, rd, f);
        check("u2 read after abort", rd, 32'h7777_7777);

        @(posedge clk); @(posedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
